// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the RAM DMA engine: bus widths, mode
// encodings and the 2-bit FSM state encoding.
package ram_dma_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    localparam logic DMA_MODE_COPY = 1'b0;
    localparam logic DMA_MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_RD   = 2'd1,
        DMA_WR   = 2'd2,
        DMA_DONE = 2'd3
    } dma_state_e;

endpackage

// File: rtl/ram_dma.sv
// Bus-initiator DMA: copies a byte-length region word by word, or fills a
// region with a constant word, through the data RAM's write/read ports.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [WORD_W-1:0] fill_data_i,
    input  logic              bus_gnt_i,
    input  logic [WORD_W-1:0] r_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] r_addr_o,
    output logic              w_en_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [WORD_W-1:0] w_data_o,
    output logic [3:0]        w_sel_o
);

    dma_state_e        state, next_state;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [LEN_W-1:0]  rem;
    logic              mode;
    logic [WORD_W-1:0] fill_word;
    logic [WORD_W-1:0] data_q;
    logic              err_flag;

    logic cfg_bad;
    logic last_word;

    function automatic logic [3:0] tail_mask(input logic [LEN_W-1:0] r);
        logic [3:0] m;
        if (r >= LEN_W'(4)) begin
            m = 4'b1111;
        end else begin
            case (r[1:0])
                2'd1:    m = 4'b0001;
                2'd2:    m = 4'b0011;
                2'd3:    m = 4'b0111;
                default: m = 4'b0000;
            endcase
        end
        return m;
    endfunction

    // Source alignment only matters for copy; fill never reads the RAM.
    assign cfg_bad   = ((mode_i == DMA_MODE_COPY) && (src_addr_i[1:0] != 2'b00)) ||
                       (dst_addr_i[1:0] != 2'b00);
    assign last_word = (rem <= LEN_W'(4));

    always_comb begin
        next_state = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        bus_req_o  = 1'b0;
        w_en_o     = 1'b0;
        w_data_o   = '0;
        w_sel_o    = 4'b0000;
        case (state)
            DMA_IDLE: begin
                if (start_i) begin
                    if (cfg_bad || (len_i == '0)) begin
                        next_state = DMA_DONE;
                    end else if (mode_i == DMA_MODE_COPY) begin
                        next_state = DMA_RD;
                    end else begin
                        next_state = DMA_WR;
                    end
                end
            end
            DMA_RD: begin
                busy_o    = 1'b1;
                bus_req_o = 1'b1;
                if (bus_gnt_i) begin
                    next_state = DMA_WR;
                end
            end
            DMA_WR: begin
                busy_o    = 1'b1;
                bus_req_o = 1'b1;
                w_en_o    = bus_gnt_i;
                w_data_o  = (mode == DMA_MODE_FILL) ? fill_word : data_q;
                w_sel_o   = tail_mask(rem);
                if (bus_gnt_i) begin
                    if (last_word) begin
                        next_state = DMA_DONE;
                    end else if (mode == DMA_MODE_COPY) begin
                        next_state = DMA_RD;
                    end
                end
            end
            DMA_DONE: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                err_o      = err_flag;
                next_state = DMA_IDLE;
            end
            default: next_state = DMA_IDLE;
        endcase
    end

    // Pointers are visible in every state so the address buses stay registered.
    assign r_addr_o = src_ptr;
    assign w_addr_o = dst_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DMA_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            rem       <= '0;
            mode      <= DMA_MODE_COPY;
            fill_word <= '0;
            data_q    <= '0;
            err_flag  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                DMA_IDLE: begin
                    if (start_i) begin
                        src_ptr   <= src_addr_i;
                        dst_ptr   <= dst_addr_i;
                        rem       <= len_i;
                        mode      <= mode_i;
                        fill_word <= fill_data_i;
                        err_flag  <= cfg_bad;
                    end
                end
                DMA_RD: begin
                    if (bus_gnt_i) begin
                        data_q <= r_data_i;
                    end
                end
                DMA_WR: begin
                    if (bus_gnt_i) begin
                        dst_ptr <= dst_ptr + ADDR_W'(4);
                        if (mode == DMA_MODE_COPY) begin
                            src_ptr <= src_ptr + ADDR_W'(4);
                        end
                        rem <= last_word ? '0 : (rem - LEN_W'(4));
                    end
                end
                DMA_DONE: begin
                    err_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
